// File: rtl/dram_fifo_wr_arbiter.sv
// Packs 16-bit words from two requesters into 128-bit DRAM FIFO beats, round-robin per beat.
// Optional partial-beat flush on idle timeout: define DRAM_FIFO_WR_FLUSH_EN.
module dram_fifo_wr_arbiter #(
  parameter logic [15:0] PAD_WORD      = 16'h0000,
  parameter int unsigned FLUSH_TIMEOUT = 1024,
  parameter int unsigned TIMEOUT_W     = 16
) (
  input  logic         ifclk,
  input  logic         reset,
  input  logic [15:0]  req0_data,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [15:0]  req1_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  output logic [127:0] fifo_data_in,
  output logic         fifo_wr_en,
  input  logic         fifo_wr_full,
  input  logic         fifo_wr_err,
  output logic         grant,
  output logic         busy,
  output logic [31:0]  beat_count,
  output logic [7:0]   err_count
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned LANES  = 8;
  localparam int unsigned LANE_W = 3;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

  state_t              state, state_nxt;
  logic [LANE_W-1:0]   lane;
  logic                rr_ptr;
  logic                grant_nxt;
  logic                accept;
  logic                flush;
  logic [WORD_W-1:0]   word;

  // Readies are a function of state/grant only, so accept never loops back through the FSM.
  assign accept = (state == COLLECT) && (grant ? req1_valid : req0_valid);
  assign word   = grant ? req1_data : req0_data;
  assign busy   = (state != IDLE);

`ifdef DRAM_FIFO_WR_FLUSH_EN
  logic [TIMEOUT_W-1:0] timer;

  // Counts stalled cycles of a started beat; an empty beat never times out.
  always_ff @(posedge ifclk) begin
    if (reset) begin
      timer <= '0;
    end else if ((state == COLLECT) && (lane != '0) && !accept) begin
      timer <= timer + TIMEOUT_W'(1);
    end else begin
      timer <= '0;
    end
  end

  assign flush = (state == COLLECT) && (lane != '0) && !accept &&
                 (timer == TIMEOUT_W'(FLUSH_TIMEOUT - 1));
`else
  assign flush = 1'b0;
`endif

  // State register
  always_ff @(posedge ifclk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, ownership and handshake strobes
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    fifo_wr_en = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          state_nxt = COLLECT;
          if (req0_valid && req1_valid) begin
            grant_nxt = rr_ptr;
          end else begin
            grant_nxt = req1_valid;
          end
        end
      end
      COLLECT: begin
        req0_ready = !grant;
        req1_ready = grant;
        if ((accept && (lane == LANE_W'(LANES - 1))) || flush) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        fifo_wr_en = !fifo_wr_full;
        if (!fifo_wr_full) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat assembly, round-robin pointer and statistics
  always_ff @(posedge ifclk) begin
    if (reset) begin
      lane         <= '0;
      rr_ptr       <= 1'b0;
      grant        <= 1'b0;
      fifo_data_in <= '0;
      beat_count   <= '0;
      err_count    <= '0;
    end else begin
      grant <= grant_nxt;
      if ((state == IDLE) && (req0_valid || req1_valid)) begin
        lane <= '0;
      end
      if (accept) begin
        fifo_data_in[lane*WORD_W +: WORD_W] <= word;
        lane <= lane + LANE_W'(1);
      end
`ifdef DRAM_FIFO_WR_FLUSH_EN
      if (flush) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (LANE_W'(i) >= lane) begin
            fifo_data_in[i*WORD_W +: WORD_W] <= PAD_WORD;
          end
        end
      end
`endif
      if (fifo_wr_en) begin
        beat_count <= beat_count + 32'd1;
        rr_ptr     <= ~grant;
        lane       <= '0;
      end
      if (fifo_wr_err && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule
